// File: rtl/crc12_framer_if.sv
// Byte-stream handshake bundle shared by the framer's upstream and downstream ports.
interface crc12_framer_if;
    logic       valid;
    logic       ready;
    logic [7:0] data;
    logic       last;

    modport master (output valid, output data, output last, input ready);
    modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/crc12_framer.sv
// CRC-12 (poly 0x80F, init 0xFFF) transmit framer: passes payload through and appends CRC hi/lo.
// Optional frame statistics counter enabled by defining CRC12_FRAMER_STATS_EN.
module crc12_framer #(
    parameter int unsigned MAX_LEN = 1024
) (
    input  logic                  clk,
    input  logic                  arst,
    crc12_framer_if.slave         s,
    crc12_framer_if.master        m,
    output logic                  busy,
    output logic                  err_len,
    output logic [15:0]           frame_count
);

    typedef enum logic [1:0] {StIdle, StData, StCrcHi, StCrcLo} state_e;

    state_e      state_q;
    logic [11:0] crc_q;
    logic [11:0] crc_step;
    logic [15:0] count_q;
    logic        m_valid_q;
    logic        m_last_q;
    logic [7:0]  m_data_q;
    logic        out_free;
    logic        accept;
    logic        hit_max;
    logic        end_frame;
    logic        lo_taken;

    function automatic logic [11:0] crc12_byte(input logic [11:0] crc_in, input logic [7:0] d);
        logic [11:0] c;
        logic        fb;
        c = crc_in;
        for (int i = 0; i < 8; i++) begin
            fb = c[11] ^ d[i];
            c  = {c[10:0], 1'b0} ^ (fb ? 12'h80F : 12'h000);
        end
        return c;
    endfunction

    assign out_free  = !m_valid_q || m.ready;
    assign s.ready   = ((state_q == StIdle) || (state_q == StData)) && out_free && !arst;
    assign accept    = s.valid && s.ready;
    assign hit_max   = (({16'h0000, count_q} + 32'd1) == MAX_LEN);
    assign end_frame = s.last || hit_max;
    assign crc_step  = crc12_byte(crc_q, s.data);
    assign lo_taken  = m_valid_q && m.ready && m_last_q;

    assign m.valid = m_valid_q;
    assign m.data  = m_data_q;
    assign m.last  = m_last_q;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q   <= StIdle;
            crc_q     <= 12'hFFF;
            count_q   <= 16'h0000;
            m_valid_q <= 1'b0;
            m_data_q  <= 8'h00;
            m_last_q  <= 1'b0;
            busy      <= 1'b0;
            err_len   <= 1'b0;
        end else begin
            err_len <= 1'b0;
            if (m_valid_q && m.ready) begin
                m_valid_q <= 1'b0;
            end
            if (lo_taken) begin
                busy <= 1'b0;
            end
            unique case (state_q)
                StIdle, StData: begin
                    if (accept) begin
                        m_data_q  <= s.data;
                        m_valid_q <= 1'b1;
                        m_last_q  <= 1'b0;
                        crc_q     <= crc_step;
                        count_q   <= count_q + 16'd1;
                        // A new frame may start in the cycle the previous CRC low byte leaves.
                        busy      <= 1'b1;
                        if (end_frame) begin
                            state_q <= StCrcHi;
                            err_len <= !s.last;
                        end else begin
                            state_q <= StData;
                        end
                    end
                end
                StCrcHi: begin
                    if (out_free) begin
                        m_data_q  <= {4'h0, crc_q[11:8]};
                        m_valid_q <= 1'b1;
                        m_last_q  <= 1'b0;
                        state_q   <= StCrcLo;
                    end
                end
                StCrcLo: begin
                    if (out_free) begin
                        m_data_q  <= crc_q[7:0];
                        m_valid_q <= 1'b1;
                        m_last_q  <= 1'b1;
                        crc_q     <= 12'hFFF;
                        count_q   <= 16'h0000;
                        state_q   <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef CRC12_FRAMER_STATS_EN
    logic [15:0] frame_count_q;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            frame_count_q <= 16'h0000;
        end else if (lo_taken) begin
            frame_count_q <= frame_count_q + 16'd1;
        end
    end

    assign frame_count = frame_count_q;
`else
    assign frame_count = 16'h0000;
`endif

endmodule

// File: tb/tb_crc12_framer.sv
// Directed bench for crc12_framer: scoreboard of expected output bytes checked by a monitor.
module tb_crc12_framer;

    logic        clk = 1'b0;
    logic        arst;
    logic        busy, err_len, busy4, err4;
    logic [15:0] frame_count, frame_count4;
    logic        bp_en = 1'b0;

    crc12_framer_if s_if ();
    crc12_framer_if m_if ();
    crc12_framer_if s4_if ();
    crc12_framer_if m4_if ();

    always #5 clk = ~clk;

    crc12_framer #(.MAX_LEN(1024)) dut (
        .clk(clk), .arst(arst), .s(s_if), .m(m_if),
        .busy(busy), .err_len(err_len), .frame_count(frame_count)
    );

    crc12_framer #(.MAX_LEN(4)) dut4 (
        .clk(clk), .arst(arst), .s(s4_if), .m(m4_if),
        .busy(busy4), .err_len(err4), .frame_count(frame_count4)
    );

    int          checks = 0;
    int          errors = 0;
    int          err4_pulses = 0;
    logic [8:0]  exp_q[$];
    logic [8:0]  exp4_q[$];
    logic [8:0]  rx_q[$];
    logic [11:0] mcrc = 12'hFFF;
    logic [11:0] mcrc4 = 12'hFFF;
    int          mcnt4 = 0;
    logic        prev_stall = 1'b0;
    logic [8:0]  prev_out = 9'h000;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference bit-serial CRC-12, LSB of each byte first.
    function automatic logic [11:0] ref_crc(input logic [11:0] c0, input logic [7:0] d);
        logic [11:0] c;
        c = c0;
        for (int i = 0; i < 8; i++) begin
            if (c[11] != d[i]) c = {c[10:0], 1'b0} ^ 12'h80F;
            else               c = {c[10:0], 1'b0};
        end
        return c;
    endfunction

    function automatic logic [31:0] pop_rx();
        if (rx_q.size() == 0) return 32'hDEAD;
        return {23'b0, rx_q.pop_front()};
    endfunction

    always @(negedge clk) begin
        if (arst) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall)
                chk("stall_hold", {22'b0, m_if.valid, m_if.last, m_if.data}, {22'b0, 1'b1, prev_out});
            if (m_if.valid && m_if.ready) begin
                chk("out_byte", {23'b0, m_if.last, m_if.data},
                    (exp_q.size() > 0) ? {23'b0, exp_q.pop_front()} : 32'h3FF);
                rx_q.push_back({m_if.last, m_if.data});
            end
            prev_stall <= m_if.valid && !m_if.ready;
            prev_out   <= {m_if.last, m_if.data};
        end
    end

    always @(negedge clk) begin
        if (!arst) begin
            if (err4) err4_pulses++;
            if (m4_if.valid && m4_if.ready)
                chk("out4_byte", {23'b0, m4_if.last, m4_if.data},
                    (exp4_q.size() > 0) ? {23'b0, exp4_q.pop_front()} : 32'h3FF);
        end
    end

    initial begin
        m_if.ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_if.ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic send(input logic [7:0] d, input logic l);
        int   t;
        logic ok;
        t  = 0;
        ok = 1'b0;
        s_if.valid = 1'b1;
        s_if.data  = d;
        s_if.last  = l;
        while (!ok && t < 300) begin
            @(negedge clk);
            if (s_if.ready) ok = 1'b1;
            else begin
                @(posedge clk);
                #1;
                t++;
            end
        end
        chk("send_accepted", {31'b0, ok}, 32'd1);
        if (ok) begin
            exp_q.push_back({1'b0, d});
            mcrc = ref_crc(mcrc, d);
            if (l) begin
                exp_q.push_back({1'b0, 4'h0, mcrc[11:8]});
                exp_q.push_back({1'b1, mcrc[7:0]});
                mcrc = 12'hFFF;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send4(input logic [7:0] d);
        int   t;
        logic ok;
        t  = 0;
        ok = 1'b0;
        s4_if.valid = 1'b1;
        s4_if.data  = d;
        s4_if.last  = 1'b0;
        while (!ok && t < 300) begin
            @(negedge clk);
            if (s4_if.ready) ok = 1'b1;
            else begin
                @(posedge clk);
                #1;
                t++;
            end
        end
        chk("send4_accepted", {31'b0, ok}, 32'd1);
        if (ok) begin
            exp4_q.push_back({1'b0, d});
            mcrc4 = ref_crc(mcrc4, d);
            mcnt4++;
            if (mcnt4 == 4) begin
                exp4_q.push_back({1'b0, 4'h0, mcrc4[11:8]});
                exp4_q.push_back({1'b1, mcrc4[7:0]});
                mcrc4 = 12'hFFF;
                mcnt4 = 0;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain(input string tag);
        int t;
        t = 0;
        while ((exp_q.size() != 0 || m_if.valid) && t < 500) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk(tag, exp_q.size(), 0);
    endtask

    initial begin
        arst = 1'b1;
        s_if.valid = 1'b0; s_if.data = 8'h00; s_if.last = 1'b0;
        s4_if.valid = 1'b0; s4_if.data = 8'h00; s4_if.last = 1'b0;
        m4_if.ready = 1'b1;
        #2;
        chk("s_ready_in_reset", {31'b0, s_if.ready}, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_m_valid", {31'b0, m_if.valid}, 0);
        chk("rst_m_data", {24'b0, m_if.data}, 0);
        chk("rst_m_last", {31'b0, m_if.last}, 0);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_err_len", {31'b0, err_len}, 0);
        chk("rst_frame_count", {16'b0, frame_count}, 0);
        arst = 1'b0;
        @(negedge clk);
        chk("s_ready_after_reset", {31'b0, s_if.ready}, 1);
        @(posedge clk);
        #1;

        // Single-byte frame 0x00.
        rx_q.delete();
        send(8'h00, 1'b1);
        s_if.valid = 1'b0;
        chk("busy_in_frame", {31'b0, busy}, 1);
        @(negedge clk); chk("gap_ready_1", {31'b0, s_if.ready}, 0);
        @(negedge clk); chk("gap_ready_2", {31'b0, s_if.ready}, 0);
        @(negedge clk); chk("gap_ready_3", {31'b0, s_if.ready}, 1);
        drain("drain_single");
        chk("single_b0", pop_rx(), 32'h000);
        chk("single_crc_hi", pop_rx(), 32'h009);
        chk("single_crc_lo", pop_rx(), 32'h106);
        chk("busy_after_frame", {31'b0, busy}, 0);

        // Two back-to-back one-byte frames.
        rx_q.delete();
        send(8'h00, 1'b1);
        send(8'h00, 1'b1);
        s_if.valid = 1'b0;
        drain("drain_b2b");
        chk("b2b_0", pop_rx(), 32'h000);
        chk("b2b_1", pop_rx(), 32'h009);
        chk("b2b_2", pop_rx(), 32'h106);
        chk("b2b_3", pop_rx(), 32'h000);
        chk("b2b_4", pop_rx(), 32'h009);
        chk("b2b_5", pop_rx(), 32'h106);

        // 16-byte frame with random downstream backpressure.
        bp_en = 1'b1;
        for (int i = 0; i < 16; i++) send(8'($urandom_range(0, 255)), (i == 15));
        s_if.valid = 1'b0;
        drain("drain_bp");
        bp_en = 1'b0;
        @(posedge clk);
        #1;

        // MAX_LEN=4 instance: 6 bytes with no s_last.
        for (int i = 0; i < 6; i++) begin
            send4(8'(8'h31 + i));
            if (i == 3) chk("err_len_after_max", {31'b0, err4}, 1);
        end
        s4_if.valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("err_len_pulses", err4_pulses, 1);
        chk("max_len_queue_empty", exp4_q.size(), 0);
        chk("max_len_new_frame_busy", {31'b0, busy4}, 1);

        // Abort a frame after 3 of 8 bytes.
        send(8'hA5, 1'b0);
        send(8'h5A, 1'b0);
        send(8'h3C, 1'b0);
        s_if.valid = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1;
        arst = 1'b1;
        #1;
        chk("abort_s_ready", {31'b0, s_if.ready}, 0);
        chk("abort_m_valid", {31'b0, m_if.valid}, 0);
        chk("abort_busy", {31'b0, busy}, 0);
        chk("abort_no_pending", exp_q.size(), 0);
        exp_q.delete();
        mcrc = 12'hFFF;
        @(posedge clk);
        #1;
        arst = 1'b0;
        exp4_q.delete();
        mcrc4 = 12'hFFF;
        mcnt4 = 0;
        rx_q.delete();
        send(8'h00, 1'b1);
        s_if.valid = 1'b0;
        drain("drain_after_abort");
        chk("abort_new_b0", pop_rx(), 32'h000);
        chk("abort_new_hi", pop_rx(), 32'h009);
        chk("abort_new_lo", pop_rx(), 32'h106);
        chk("abort_rx_empty", rx_q.size(), 0);

`ifdef CRC12_FRAMER_STATS_EN
        chk("stats_one", {16'b0, frame_count}, 1);
        send(8'h12, 1'b1);
        send(8'h34, 1'b1);
        s_if.valid = 1'b0;
        drain("drain_stats");
        chk("stats_three", {16'b0, frame_count}, 3);
        force dut.frame_count_q = 16'hFFFF;
        @(posedge clk);
        #1;
        release dut.frame_count_q;
        send(8'h00, 1'b1);
        s_if.valid = 1'b0;
        drain("drain_wrap");
        chk("stats_wrap", {16'b0, frame_count}, 0);
`else
        chk("frame_count_tied", {16'b0, frame_count}, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
